tiger_wb_arbiter: RTL and testbench

TIGER_WB_ARBITER -- requirements
Module: tiger_wb_arbiter

---
 rtl/tiger_defines.sv | 16 +
 rtl/tiger_wb_fifo.sv | 78 +++++++
 rtl/tiger_wb_arbiter.sv | 114 +++++++++++
 tb/tb_tiger_wb_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tiger_defines.sv
// Shared register-file write definitions used by the writeback arbiter and its buffer.
package tiger_defines;

    localparam int REGNUM_W = 5;
    localparam int DATA_W   = 32;

    typedef logic [REGNUM_W-1:0] regnum_t;
    typedef logic [DATA_W-1:0]   word_t;

    // One buffered late-result write: destination register and data.
    typedef struct packed {
        regnum_t num;
        word_t   data;
    } lt_req_t;

endpackage

// File: rtl/tiger_wb_fifo.sv
// Circular buffer of late-result writes. Every entry carries a valid bit that a
// younger writeback to the same register can clear; invalid entries still
// occupy their slot until dequeued.
module tiger_wb_fifo
    import tiger_defines::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  lt_req_t push_req,
    input  logic    pop,
    input  logic    inv_en,
    input  regnum_t inv_num,
    output logic    full,
    output logic    empty,
    output logic    head_valid,
    output lt_req_t head_req
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;

    lt_req_t          entry_vec [DEPTH];
    logic [DEPTH-1:0] valid_vec;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            lt_req_t entry_reg;
            logic    valid_reg;

            // A push claims the slot; otherwise a matching writeback kills the
            // older entry. The push wins so a same-cycle younger lt write survives.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    entry_reg <= '0;
                    valid_reg <= 1'b0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= push_req;
                    valid_reg <= 1'b1;
                end else if (inv_en && (entry_reg.num == inv_num)) begin
                    valid_reg <= 1'b0;
                end
            end

            assign entry_vec[gi] = entry_reg;
            assign valid_vec[gi] = valid_reg;
        end
    endgenerate

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign full       = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty      = (count_reg == '0);
    assign head_valid = valid_vec[rd_ptr_reg];
    assign head_req   = entry_vec[rd_ptr_reg];

endmodule

// File: rtl/tiger_wb_arbiter.sv
// Register-file write-port arbiter: writeback stage has priority, late
// (multi-cycle) results queue in a small buffer and fill idle port cycles.
module tiger_wb_arbiter
    import tiger_defines::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wb_en,
    input  logic                wb_cop,
    input  logic [REGNUM_W-1:0] wb_num,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                lt_valid,
    input  logic [REGNUM_W-1:0] lt_num,
    input  logic [DATA_W-1:0]   lt_data,
    output logic                lt_ready,
    output logic                rf_we,
    output logic                rf_we_cop,
    output logic [REGNUM_W-1:0] rf_num,
    output logic [DATA_W-1:0]   rf_data,
    output logic                stall_req
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic    fifo_full, fifo_empty, head_valid;
    lt_req_t head_req;
    logic    lt_push, fifo_pop, head_live, lt_issue, inv_en;

    logic                rf_we_reg, rf_we_next;
    logic                rf_we_cop_reg, rf_we_cop_next;
    logic [REGNUM_W-1:0] rf_num_reg, rf_num_next;
    logic [DATA_W-1:0]   rf_data_reg, rf_data_next;
    logic [STARVE_W-1:0] starve_reg, starve_next;
    logic                stall_reg, stall_next;

    assign lt_ready  = !fifo_full;
    assign lt_push   = lt_valid && !fifo_full;
    // Dead heads (invalidated or r0) never need the port, so they drain even under wb traffic.
    assign head_live = head_valid && (head_req.num != '0);
    assign fifo_pop  = !fifo_empty && (!wb_en || !head_live);
    assign lt_issue  = fifo_pop && head_live;
    assign inv_en    = wb_en && !wb_cop && (wb_num != '0);

    tiger_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (lt_push),
        .push_req   ('{num: lt_num, data: lt_data}),
        .pop        (fifo_pop),
        .inv_en     (inv_en),
        .inv_num    (wb_num),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_valid (head_valid),
        .head_req   (head_req)
    );

    // Port selection and starvation tracking for the next cycle.
    always_comb begin
        rf_we_next     = 1'b0;
        rf_we_cop_next = 1'b0;
        rf_num_next    = rf_num_reg;
        rf_data_next   = rf_data_reg;
        if (wb_en) begin
            rf_we_next     = !wb_cop && (wb_num != '0);
            rf_we_cop_next = wb_cop;
            rf_num_next    = wb_num;
            rf_data_next   = wb_data;
        end else if (lt_issue) begin
            rf_we_next     = 1'b1;
            rf_num_next    = head_req.num;
            rf_data_next   = head_req.data;
        end

        starve_next = starve_reg;
        if (fifo_empty || fifo_pop) begin
            starve_next = '0;
        end else if (wb_en && (starve_reg != STARVE_W'(STARVE_LIMIT))) begin
            starve_next = starve_reg + 1'b1;
        end
        stall_next = (starve_next == STARVE_W'(STARVE_LIMIT));
    end

    // Registered write port, starve counter and stall request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we_reg     <= 1'b0;
            rf_we_cop_reg <= 1'b0;
            rf_num_reg    <= '0;
            rf_data_reg   <= '0;
            starve_reg    <= '0;
            stall_reg     <= 1'b0;
        end else begin
            rf_we_reg     <= rf_we_next;
            rf_we_cop_reg <= rf_we_cop_next;
            rf_num_reg    <= rf_num_next;
            rf_data_reg   <= rf_data_next;
            starve_reg    <= starve_next;
            stall_reg     <= stall_next;
        end
    end

    assign rf_we     = rf_we_reg;
    assign rf_we_cop = rf_we_cop_reg;
    assign rf_num    = rf_num_reg;
    assign rf_data   = rf_data_reg;
    assign stall_req = stall_reg;

endmodule

// File: tb/tb_tiger_wb_arbiter.sv
// Directed bench for tiger_wb_arbiter with a write scoreboard on the port.
module tb_tiger_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_en, wb_cop, lt_valid;
    logic [4:0]  wb_num, lt_num;
    logic [31:0] wb_data, lt_data;
    logic        lt_ready, rf_we, rf_we_cop, stall_req;
    logic [4:0]  rf_num;
    logic [31:0] rf_data;

    typedef struct {
        logic        cop;
        logic [4:0]  num;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    tiger_wb_arbiter #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wb_en     (wb_en),
        .wb_cop    (wb_cop),
        .wb_num    (wb_num),
        .wb_data   (wb_data),
        .lt_valid  (lt_valid),
        .lt_num    (lt_num),
        .lt_data   (lt_data),
        .lt_ready  (lt_ready),
        .rf_we     (rf_we),
        .rf_we_cop (rf_we_cop),
        .rf_num    (rf_num),
        .rf_data   (rf_data),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic expect_write(input logic cop, input logic [4:0] num, input logic [31:0] data);
        exp_t e;
        e.cop  = cop;
        e.num  = num;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Advance one clock and score whatever the port wrote.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (rf_we === 1'b1 || rf_we_cop === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {25'd0, rf_we, rf_we_cop, rf_num, rf_data}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("port_write", {25'd0, rf_we, rf_we_cop, rf_num, rf_data},
                    {25'd0, ~e.cop, e.cop, e.num, e.data});
                $display("t=%0t write cop=%0d r%0d data=%h", $time, rf_we_cop, rf_num, rf_data);
            end
        end
    endtask

    task automatic drive_wb(input logic en, input logic cop, input logic [4:0] num, input logic [31:0] data);
        wb_en   = en;
        wb_cop  = cop;
        wb_num  = num;
        wb_data = data;
    endtask

    task automatic drive_lt(input logic v, input logic [4:0] num, input logic [31:0] data);
        lt_valid = v;
        lt_num   = num;
        lt_data  = data;
    endtask

    initial begin
        reset_n = 1'b0;
        drive_wb(0, 0, 0, 0);
        drive_lt(0, 0, 0);
        tick();
        tick();
        chk("reset_rf_we", rf_we, 0);
        chk("reset_rf_we_cop", rf_we_cop, 0);
        chk("reset_rf_num", rf_num, 0);
        chk("reset_rf_data", rf_data, 0);
        chk("reset_stall", stall_req, 0);
        chk("reset_lt_ready", lt_ready, 1);
        reset_n = 1'b1;

        // wb write with one-cycle latency
        drive_wb(1, 0, 5, 32'hDEADBEEF);
        expect_write(0, 5, 32'hDEADBEEF);
        tick();
        drive_wb(0, 0, 0, 0);
        chk("wb_latency", exp_q.size(), 0);

        // lt write into empty buffer, wb idle: two-cycle latency
        drive_lt(1, 7, 32'h11);
        chk("lt_ready_empty", lt_ready, 1);
        expect_write(0, 7, 32'h11);
        tick();
        drive_lt(0, 0, 0);
        chk("lt_not_early", rf_we, 0);
        tick();
        chk("lt_latency", exp_q.size(), 0);

        // fill buffer under wb traffic, then drain in order
        drive_wb(1, 0, 1, 32'h100);
        drive_lt(1, 3, 32'h33);
        expect_write(0, 1, 32'h100);
        tick();
        drive_wb(1, 0, 2, 32'h200);
        drive_lt(1, 4, 32'h44);
        expect_write(0, 2, 32'h200);
        tick();
        drive_wb(1, 0, 6, 32'h600);
        drive_lt(1, 5, 32'h55);
        chk("full_lt_ready", lt_ready, 0);
        expect_write(0, 6, 32'h600);
        tick();
        drive_wb(0, 0, 0, 0);
        chk("full_still_blocked", lt_ready, 0);
        expect_write(0, 3, 32'h33);
        tick();
        chk("drain_r3_done", exp_q.size(), 0);
        expect_write(0, 4, 32'h44);
        tick();
        drive_lt(0, 0, 0);
        chk("drain_r4_done", exp_q.size(), 0);
        expect_write(0, 5, 32'h55);
        tick();
        chk("held_r5_done", exp_q.size(), 0);
        chk("drained_lt_ready", lt_ready, 1);
        chk("no_stall_short", stall_req, 0);

        // buffered r9 overwritten by younger wb r9
        drive_wb(1, 0, 8, 32'h80);
        drive_lt(1, 9, 32'hA);
        expect_write(0, 8, 32'h80);
        tick();
        drive_lt(0, 0, 0);
        drive_wb(1, 0, 9, 32'hB);
        expect_write(0, 9, 32'hB);
        tick();
        drive_wb(0, 0, 0, 0);
        tick();
        chk("inv_no_write", rf_we, 0);
        tick();
        chk("inv_idle", rf_we, 0);
        chk("inv_queue", exp_q.size(), 0);
        chk("inv_lt_ready", lt_ready, 1);

        // starvation: entry waits while wb keeps the port
        drive_wb(1, 0, 10, 32'h1000);
        drive_lt(1, 11, 32'hBB);
        expect_write(0, 10, 32'h1000);
        tick();
        drive_lt(0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            drive_wb(1, 0, 10, 32'h1000 + i);
            expect_write(0, 10, 32'h1000 + i);
            tick();
            chk($sformatf("stall_after_%0d", i), stall_req, (i == 4) ? 1 : 0);
        end
        drive_wb(1, 0, 10, 32'h2000);
        expect_write(0, 10, 32'h2000);
        tick();
        chk("stall_saturated", stall_req, 1);
        drive_wb(0, 0, 0, 0);
        expect_write(0, 11, 32'hBB);
        tick();
        chk("starved_issued", exp_q.size(), 0);
        chk("stall_cleared", stall_req, 0);

        // r0 writes from both sources are suppressed
        drive_wb(1, 0, 0, 32'hF00D);
        drive_lt(1, 0, 32'hBAD);
        tick();
        drive_wb(0, 0, 0, 0);
        drive_lt(0, 0, 0);
        chk("r0_wb_no_we", rf_we, 0);
        tick();
        chk("r0_lt_no_we", rf_we, 0);

        // coprocessor write
        drive_wb(1, 1, 12, 32'hC0C0);
        expect_write(1, 12, 32'hC0C0);
        tick();
        drive_wb(0, 0, 0, 0);
        chk("cop_we_cop", rf_we_cop, 1);
        chk("cop_we", rf_we, 0);

        // reset mid-stream with r14 buffered
        drive_wb(1, 0, 13, 32'h1313);
        drive_lt(1, 14, 32'h1414);
        expect_write(0, 13, 32'h1313);
        tick();
        drive_wb(0, 0, 0, 0);
        drive_lt(0, 0, 0);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {rf_we, rf_we_cop, rf_num, rf_data, stall_req}, 0);
        chk("mid_reset_lt_ready", lt_ready, 1);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_reset_idle", rf_we, 0);
        tick();
        chk("post_reset_discarded", rf_we, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
